// File: rtl/mult_issue_stage.sv
// mult_issue_stage: issue/writeback wrapper around the iterative Booth multiplier.
// Accepts one tagged multiply and starts the multiplier. Holds the operands for
// the whole multiply. Captures the product into a one-entry output register,
// with a one-entry skid register for when the CDB is not accepting.
//
// Ports
//   clk, reset      : clock, asynchronous active-low reset
//   in_valid/ready  : op handshake from the multiply reservation station
//   in_a/in_b/in_tag: operands and destination tag
//   flush           : squash the in-flight op and any buffered result
//   mult_rst        : start/clear pulse to the multiplier (high in START and in reset)
//   mult_a/mult_b   : operands held to the multiplier
//   mult_result/done/ovf : multiplier completion inputs
//   out_valid/ready : result handshake to the CDB
//   out_result/ovf/tag : tagged result
//   wd_err          : sticky watchdog error
module mult_issue_stage #(
  parameter int unsigned TAG_W    = 6,
  parameter int unsigned WD_LIMIT = 40
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             mult_rst,
  output logic [31:0]      mult_a,
  output logic [31:0]      mult_b,
  input  logic [31:0]      mult_result,
  input  logic             mult_done,
  input  logic             mult_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag,
  output logic             wd_err
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = $clog2(WD_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    HOLD  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   op_a_q, op_a_d;
  logic [DATA_W-1:0]   op_b_q, op_b_d;
  logic [TAG_W-1:0]    op_tag_q, op_tag_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   skid_result_q, skid_result_d;
  logic                skid_ovf_q, skid_ovf_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_result_q, out_result_d;
  logic                out_ovf_q, out_ovf_d;
  logic [TAG_W-1:0]    out_tag_q, out_tag_d;
  logic                wd_err_q, wd_err_d;
  logic                in_ready_q, in_ready_d;
  logic                mult_rst_q, mult_rst_d;

  logic                drain;
  logic                done_qual;

  // Output register is being emptied by the CDB this cycle.
  assign drain     = out_valid_q & out_ready;
  // First BUSY cycle (count 0) blanks a completion left over from the previous op.
  assign done_qual = mult_done & (cnt_q != '0);

  // Next-state and datapath logic.
  always_comb begin
    state_d       = state_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    op_tag_d      = op_tag_q;
    cnt_d         = cnt_q;
    skid_result_d = skid_result_q;
    skid_ovf_d    = skid_ovf_q;
    out_valid_d   = out_valid_q;
    out_result_d  = out_result_q;
    out_ovf_d     = out_ovf_q;
    out_tag_d     = out_tag_q;
    wd_err_d      = wd_err_q;

    if (drain) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          op_a_d   = in_a;
          op_b_d   = in_b;
          op_tag_d = in_tag;
          state_d  = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = BUSY;
      end
      BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (done_qual) begin
          if (!out_valid_q || drain) begin
            out_valid_d  = 1'b1;
            out_result_d = mult_result;
            out_ovf_d    = mult_ovf;
            out_tag_d    = op_tag_q;
            state_d      = IDLE;
          end else begin
            skid_result_d = mult_result;
            skid_ovf_d    = mult_ovf;
            state_d       = HOLD;
          end
        end else if (cnt_q == CNT_W'(WD_LIMIT - 1)) begin
          // Multiplier never finished: drop the op and flag it.
          wd_err_d = 1'b1;
          state_d  = IDLE;
        end
      end
      HOLD: begin
        if (drain) begin
          out_valid_d  = 1'b1;
          out_result_d = skid_result_q;
          out_ovf_d    = skid_ovf_q;
          out_tag_d    = op_tag_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Flush wins over every other event; the watchdog flag is kept.
    if (flush) begin
      state_d       = IDLE;
      out_valid_d   = 1'b0;
      skid_result_d = '0;
      skid_ovf_d    = 1'b0;
    end

    in_ready_d = (state_d == IDLE);
    mult_rst_d = (state_d == START);
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      op_a_q        <= '0;
      op_b_q        <= '0;
      op_tag_q      <= '0;
      cnt_q         <= '0;
      skid_result_q <= '0;
      skid_ovf_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_ovf_q     <= 1'b0;
      out_tag_q     <= '0;
      wd_err_q      <= 1'b0;
      in_ready_q    <= 1'b1;
      mult_rst_q    <= 1'b1;
    end else begin
      state_q       <= state_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      op_tag_q      <= op_tag_d;
      cnt_q         <= cnt_d;
      skid_result_q <= skid_result_d;
      skid_ovf_q    <= skid_ovf_d;
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      out_ovf_q     <= out_ovf_d;
      out_tag_q     <= out_tag_d;
      wd_err_q      <= wd_err_d;
      in_ready_q    <= in_ready_d;
      mult_rst_q    <= mult_rst_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign mult_rst   = mult_rst_q;
  assign mult_a     = op_a_q;
  assign mult_b     = op_b_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_ovf    = out_ovf_q;
  assign out_tag    = out_tag_q;
  assign wd_err     = wd_err_q;

endmodule

// File: tb/tb_mult_issue_stage.sv
// Directed testbench for mult_issue_stage with a behavioural multiplier model.
module tb_mult_issue_stage;

  localparam int unsigned TAG_W = 6;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             mult_rst;
  logic [31:0]      mult_a;
  logic [31:0]      mult_b;
  logic [31:0]      mult_result;
  logic             mult_done;
  logic             mult_ovf;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic             out_ovf;
  logic [TAG_W-1:0] out_tag;
  logic             wd_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Multiplier model: done stays high once mlat cycles have passed since mult_rst.
  int   mcnt = 0;
  int   mlat = 33;
  logic mdone_en = 1'b1;
  logic force_ovf = 1'b0;

  always @(posedge clk) begin
    if (mult_rst) mcnt <= 0;
    else if (mcnt < 1000) mcnt <= mcnt + 1;
  end
  assign mult_done   = mdone_en && (mcnt >= mlat - 1);
  assign mult_result = mult_a * mult_b;
  assign mult_ovf    = force_ovf;

  mult_issue_stage #(.TAG_W(6), .WD_LIMIT(40)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .flush(flush),
    .mult_rst(mult_rst), .mult_a(mult_a), .mult_b(mult_b),
    .mult_result(mult_result), .mult_done(mult_done), .mult_ovf(mult_ovf),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_ovf(out_ovf), .out_tag(out_tag),
    .wd_err(wd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one op for a single cycle; returns at the negedge of the START cycle.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
    in_valid = 1'b1; in_a = a; in_b = b; in_tag = t;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Issue an op and count cycles (accept cycle = 0) until out_valid; -1 on timeout.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t,
                        output int lat, output int rst_pulses);
    lat = -1; rst_pulses = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_tag = t;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (mult_rst) rst_pulses++;
      if (out_valid) begin lat = i; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_tests++; if (mult_rst !== 1'b1) begin n_fail++; $display("FAIL reset_mult_rst: got %b want 1", mult_rst); end
    n_tests++; if (mult_a !== 32'd0 || mult_b !== 32'd0) begin n_fail++; $display("FAIL reset_operands: got %h %h want 0 0", mult_a, mult_b); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_tests++; if (out_result !== 32'd0 || out_ovf !== 1'b0 || out_tag !== 6'd0) begin n_fail++; $display("FAIL reset_out_data: got %h %b %h want 0 0 0", out_result, out_ovf, out_tag); end
    n_tests++; if (wd_err !== 1'b0) begin n_fail++; $display("FAIL reset_wd_err: got %b want 0", wd_err); end
    reset = 1'b1;
    @(negedge clk);
    n_tests++; if (mult_rst !== 1'b0) begin n_fail++; $display("FAIL reset_release_mult_rst: got %b want 0", mult_rst); end
  endtask

  task automatic test_basic();
    int lat, pulses;
    mlat = 33; force_ovf = 1'b0; out_ready = 1'b1;
    run_op(32'd7, 32'd6, 6'd5, lat, pulses);
    n_tests++; if (lat !== 35) begin n_fail++; $display("FAIL basic_latency: got %0d want 35", lat); end
    n_tests++; if (pulses !== 1) begin n_fail++; $display("FAIL basic_mult_rst_pulses: got %0d want 1", pulses); end
    n_tests++; if (out_result !== 32'd42) begin n_fail++; $display("FAIL basic_result: got %h want 2a", out_result); end
    n_tests++; if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL basic_ovf: got %b want 0", out_ovf); end
    n_tests++; if (out_tag !== 6'd5) begin n_fail++; $display("FAIL basic_tag: got %h want 5", out_tag); end
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_signed();
    int lat, pulses;
    mlat = 4; force_ovf = 1'b0; out_ready = 1'b1;
    run_op(32'hFFFF_FFFD, 32'd5, 6'd9, lat, pulses);
    n_tests++; if (lat !== 6) begin n_fail++; $display("FAIL signed_latency: got %0d want 6", lat); end
    n_tests++; if (out_result !== 32'hFFFF_FFF1 || out_tag !== 6'd9) begin n_fail++; $display("FAIL signed_result: got %h tag %h want fffffff1 tag 9", out_result, out_tag); end
    @(negedge clk);
    force_ovf = 1'b1;
    run_op(32'h4000_0000, 32'd4, 6'd10, lat, pulses);
    n_tests++; if (out_result !== 32'd0 || out_ovf !== 1'b1 || out_tag !== 6'd10) begin n_fail++; $display("FAIL ovf_result: got %h ovf %b tag %h want 0 ovf 1 tag a", out_result, out_ovf, out_tag); end
    force_ovf = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_blanking();
    int lat, pulses;
    // Done already high on the first BUSY cycle must be ignored for one cycle.
    mlat = 1; out_ready = 1'b1;
    run_op(32'd3, 32'd3, 6'd11, lat, pulses);
    n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL blank_latency: got %0d want 4", lat); end
    n_tests++; if (out_result !== 32'd9) begin n_fail++; $display("FAIL blank_result: got %h want 9", out_result); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat, pulses;
    mlat = 4; out_ready = 1'b0;
    run_op(32'd3, 32'd4, 6'd1, lat, pulses);
    n_tests++; if (out_result !== 32'd12 || out_tag !== 6'd1) begin n_fail++; $display("FAIL b2b_first: got %h tag %h want c tag 1", out_result, out_tag); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_after_valid: got %b want 1", in_ready); end
    issue(32'd5, 32'd6, 6'd2);
    n_tests++; if (mult_rst !== 1'b1 || mult_a !== 32'd5 || mult_b !== 32'd6) begin n_fail++; $display("FAIL b2b_start: got rst %b a %h b %h want 1 5 6", mult_rst, mult_a, mult_b); end
    repeat (8) @(negedge clk);
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready: got %b want 0", in_ready); end
    n_tests++; if (out_valid !== 1'b1 || out_result !== 32'd12 || out_tag !== 6'd1) begin n_fail++; $display("FAIL hold_stable: got v %b %h tag %h want 1 c tag 1", out_valid, out_result, out_tag); end
    out_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b1 || out_result !== 32'd30 || out_tag !== 6'd2) begin n_fail++; $display("FAIL hold_second: got v %b %h tag %h want 1 1e tag 2", out_valid, out_result, out_tag); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL hold_exit_ready: got %b want 1", in_ready); end
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_final_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    int lat, pulses, seen;
    mlat = 10; out_ready = 1'b1;
    issue(32'd2, 32'd3, 6'd7);
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_idle: got in_ready %b want 1", in_ready); end
    seen = 0;
    repeat (20) begin @(negedge clk); if (out_valid) seen++; end
    n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL flush_no_result: got %0d valid cycles want 0", seen); end
    flush = 1'b1; in_valid = 1'b1; in_a = 32'd8; in_b = 32'd9; in_tag = 6'd3;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    n_tests++; if (in_ready !== 1'b1 || mult_rst !== 1'b0) begin n_fail++; $display("FAIL flush_blocks_accept: got ready %b rst %b want 1 0", in_ready, mult_rst); end
    seen = 0;
    repeat (20) begin @(negedge clk); if (out_valid) seen++; end
    n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL flush_accept_no_result: got %0d valid cycles want 0", seen); end
    run_op(32'd8, 32'd9, 6'd3, lat, pulses);
    n_tests++; if (lat !== 12 || out_result !== 32'd72 || out_tag !== 6'd3) begin n_fail++; $display("FAIL flush_later_op: got lat %0d %h tag %h want 12 48 tag 3", lat, out_result, out_tag); end
    @(negedge clk);
  endtask

  task automatic test_reset_midop();
    int seen;
    mlat = 4; out_ready = 1'b1;
    issue(32'd11, 32'd13, 6'd4);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_tests++; if (mult_rst !== 1'b1 || in_ready !== 1'b1 || mult_a !== 32'd0) begin n_fail++; $display("FAIL async_reset: got rst %b ready %b a %h want 1 1 0", mult_rst, in_ready, mult_a); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset_valid: got %b want 0", out_valid); end
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (20) begin @(negedge clk); if (out_valid) seen++; end
    n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL reset_stale_result: got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_watchdog();
    int first, lat, pulses;
    mdone_en = 1'b0; out_ready = 1'b1; first = -1;
    in_valid = 1'b1; in_a = 32'd1; in_b = 32'd1; in_tag = 6'd6;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (wd_err && first < 0) first = i;
      if (first >= 0) break;
    end
    n_tests++; if (first !== 42) begin n_fail++; $display("FAIL wd_timing: got cycle %0d want 42", first); end
    n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL wd_drop: got ready %b valid %b want 1 0", in_ready, out_valid); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (5) @(negedge clk);
    n_tests++; if (wd_err !== 1'b1) begin n_fail++; $display("FAIL wd_sticky: got %b want 1", wd_err); end
    mdone_en = 1'b1; mlat = 4;
    run_op(32'd6, 32'd7, 6'd8, lat, pulses);
    n_tests++; if (out_result !== 32'd42 || wd_err !== 1'b1) begin n_fail++; $display("FAIL wd_after_op: got %h wd %b want 2a 1", out_result, wd_err); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    n_tests++; if (wd_err !== 1'b0) begin n_fail++; $display("FAIL wd_reset_clear: got %b want 0", wd_err); end
  endtask

  initial begin
    in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0;
    flush = 1'b0; out_ready = 1'b1;
    test_reset();
    test_basic();
    test_signed();
    test_blanking();
    test_back_to_back();
    test_flush();
    test_reset_midop();
    test_watchdog();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
